// File: rtl/nibble_cpu_p_pkg.sv
// Shared opcodes, FSM state encodings and instruction-length predicate for nibble_cpu_p.
package nibble_cpu_p_pkg;

    typedef enum logic [1:0] {
        ST_FETCH      = 2'd0,
        ST_FETCH_ADDR = 2'd1,
        ST_EXEC       = 2'd2,
        ST_HALT       = 2'd3
    } state_t;

    localparam logic [3:0] OP_JC    = 4'h0;
    localparam logic [3:0] OP_JNC   = 4'h1;
    localparam logic [3:0] OP_CMPI  = 4'h2;
    localparam logic [3:0] OP_CMPM  = 4'h3;
    localparam logic [3:0] OP_LIT   = 4'h4;
    localparam logic [3:0] OP_IO    = 4'h5;
    localparam logic [3:0] OP_LD    = 4'h6;
    localparam logic [3:0] OP_ST    = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;
    localparam logic [3:0] OP_ADDI  = 4'hA;
    localparam logic [3:0] OP_ADDM  = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_NANDI = 4'hD;
    localparam logic [3:0] OP_CALL  = 4'hE;
    localparam logic [3:0] OP_RET   = 4'hF;

    // Opcodes carrying an address in a second program word.
    function automatic logic is_two_word(input logic [3:0] op);
        case (op)
            OP_JC, OP_JNC, OP_CMPM, OP_LD, OP_ST,
            OP_JZ, OP_JNZ, OP_ADDM, OP_JMP, OP_CALL: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/nibble_cpu_p_call_stack.sv
// Return-address LIFO: push writes top, pop drops it; dout shows top combinationally.
// Pointer saturates (never wraps); callers must not push when full or pop when empty.
module call_stack #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int IX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_dec;

    assign sp_dec = sp - SP_W'(1);
    assign dout   = mem[sp_dec[IX_W-1:0]];
    assign full   = (sp == SP_W'(STACK_DEPTH));
    assign empty  = (sp == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp_dec;
        end
    end

    // Entries are not cleared: only the pointer defines validity.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[sp[IX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/nibble_cpu_p.sv
// Multi-cycle accumulator CPU: 2 cycles per 1-word instruction, 3 per 2-word instruction.
// No backpressure: ROM/RAM are combinational; a stack error parks the core in HALT until reset.
module nibble_cpu_p
    import nibble_cpu_p_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int PW          = DATA_W + 4,
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [PW-1:0]     prog_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [DATA_W-1:0] pushbuttons,
    output logic [DATA_W-1:0] ff_out,
    output logic [DATA_W-1:0] accu,
    output logic [ADDR_W-1:0] pc,
    output logic              c_flag,
    output logic              z_flag,
    output logic [1:0]        phase,
    output logic              halted,
    output logic              stack_err
);
    state_t              state, state_nxt;
    logic [3:0]          instr, instr_nxt;
    logic [DATA_W-1:0]   oprnd, oprnd_nxt;
    logic [PW-1:0]       addr_lo, addr_lo_nxt;
    logic [ADDR_W-1:0]   pc_nxt, ea, stk_dout;
    logic [DATA_W-1:0]   accu_nxt, ff_nxt, alu_b;
    logic                c_nxt, z_nxt, err_nxt;
    logic                push, pop, stk_full, stk_empty;
    logic [DATA_W+1:0]   alu_out;
    logic [DATA_W+PW-1:0] ea_full;

    // Returns {carry, zero, result}; non-ALU opcodes pass A and the old flags through.
    function automatic logic [DATA_W+1:0] alu(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b, input logic c_in,
                                              input logic z_in);
        logic [DATA_W:0]   sum;
        logic [DATA_W-1:0] r;
        case (op)
            OP_ADDI, OP_ADDM: begin
                sum = {1'b0, a} + {1'b0, b};
                return {sum[DATA_W], (sum[DATA_W-1:0] == '0), sum[DATA_W-1:0]};
            end
            OP_CMPI, OP_CMPM: begin
                sum = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
                return {sum[DATA_W], (sum[DATA_W-1:0] == '0), a};
            end
            OP_NANDI: begin
                r = ~(a & b);
                return {1'b0, (r == '0), r};
            end
            default: return {c_in, z_in, a};
        endcase
    endfunction

    assign ea_full   = {oprnd, addr_lo};
    assign ea        = ea_full[ADDR_W-1:0];
    assign alu_b     = (instr == OP_CMPM || instr == OP_ADDM) ? ram_rdata : oprnd;
    assign alu_out   = alu(instr, accu, alu_b, c_flag, z_flag);
    assign prog_addr = pc;
    assign ram_addr  = (state == ST_EXEC) ? ea : '0;
    assign ram_we    = (state == ST_EXEC) && (instr == OP_ST);
    assign ram_wdata = accu;
    assign phase     = state;
    assign halted    = (state == ST_HALT);

    call_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        state_nxt   = state;
        instr_nxt   = instr;
        oprnd_nxt   = oprnd;
        addr_lo_nxt = addr_lo;
        pc_nxt      = pc;
        accu_nxt    = accu;
        c_nxt       = c_flag;
        z_nxt       = z_flag;
        ff_nxt      = ff_out;
        err_nxt     = stack_err;
        push        = 1'b0;
        pop         = 1'b0;
        case (state)
            ST_FETCH: begin
                instr_nxt = prog_data[PW-1:DATA_W];
                oprnd_nxt = prog_data[DATA_W-1:0];
                pc_nxt    = pc + ADDR_W'(1);
                state_nxt = is_two_word(prog_data[PW-1:DATA_W]) ? ST_FETCH_ADDR : ST_EXEC;
            end
            ST_FETCH_ADDR: begin
                addr_lo_nxt = prog_data;
                pc_nxt      = pc + ADDR_W'(1);
                state_nxt   = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = ST_FETCH;
                {c_nxt, z_nxt, accu_nxt} = alu_out;
                case (instr)
                    OP_LIT: accu_nxt = oprnd;
                    OP_IO: begin
                        if (oprnd[0]) ff_nxt = accu;
                        else          accu_nxt = pushbuttons;
                    end
                    OP_LD:  accu_nxt = ram_rdata;
                    OP_JC:  if (c_flag)  pc_nxt = ea;
                    OP_JNC: if (!c_flag) pc_nxt = ea;
                    OP_JZ:  if (z_flag)  pc_nxt = ea;
                    OP_JNZ: if (!z_flag) pc_nxt = ea;
                    OP_JMP: pc_nxt = ea;
                    OP_CALL: begin
                        if (stk_full) begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_HALT;
                        end else begin
                            push   = 1'b1;
                            pc_nxt = ea;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_HALT;
                        end else begin
                            pop    = 1'b1;
                            pc_nxt = stk_dout;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_FETCH;
            instr     <= '0;
            oprnd     <= '0;
            addr_lo   <= '0;
            pc        <= '0;
            accu      <= '0;
            c_flag    <= 1'b0;
            z_flag    <= 1'b0;
            ff_out    <= '0;
            stack_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            instr     <= instr_nxt;
            oprnd     <= oprnd_nxt;
            addr_lo   <= addr_lo_nxt;
            pc        <= pc_nxt;
            accu      <= accu_nxt;
            c_flag    <= c_nxt;
            z_flag    <= z_nxt;
            ff_out    <= ff_nxt;
            stack_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_nibble_cpu_p.sv
// Directed bench for nibble_cpu_p: default 4-bit build plus an 8-bit/16-bit-address build.
module tb_nibble_cpu_p;
    import nibble_cpu_p_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] prog_addr, ram_addr, pc;
    logic [7:0]  prog_data;
    logic [3:0]  ram_wdata, ram_rdata, pushbuttons, ff_out, accu;
    logic        ram_we, c_flag, z_flag, halted, stack_err;
    logic [1:0]  phase;

    logic        reset8 = 1'b1;
    logic [15:0] prog_addr8, ram_addr8, pc8;
    logic [11:0] prog_data8;
    logic [7:0]  ram_wdata8, ff_out8, accu8;
    logic        ram_we8, c_flag8, z_flag8, halted8, stack_err8;
    logic [1:0]  phase8;

    logic [7:0]  rom  [4096];
    logic [3:0]  ram  [4096];
    logic [11:0] rom8 [65536];
    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int we0;

    always #5 clock = ~clock;

    assign prog_data  = rom[prog_addr];
    assign ram_rdata  = ram[ram_addr];
    assign prog_data8 = rom8[prog_addr8];

    always @(posedge clock) if (ram_we) ram[ram_addr] <= ram_wdata;
    always @(negedge clock) if (ram_we) we_cnt = we_cnt + 1;

    nibble_cpu_p dut (
        .clock(clock), .reset(reset), .prog_addr(prog_addr), .prog_data(prog_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .pushbuttons(pushbuttons), .ff_out(ff_out), .accu(accu), .pc(pc),
        .c_flag(c_flag), .z_flag(z_flag), .phase(phase), .halted(halted), .stack_err(stack_err)
    );

    nibble_cpu_p #(.DATA_W(8), .ADDR_W(16)) dut8 (
        .clock(clock), .reset(reset8), .prog_addr(prog_addr8), .prog_data(prog_data8),
        .ram_addr(ram_addr8), .ram_wdata(ram_wdata8), .ram_we(ram_we8), .ram_rdata(8'h00),
        .pushbuttons(8'h00), .ff_out(ff_out8), .accu(accu8), .pc(pc8),
        .c_flag(c_flag8), .z_flag(z_flag8), .phase(phase8), .halted(halted8), .stack_err(stack_err8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Hold the default core in reset and blank its memories before loading a program.
    task automatic begin_test();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            rom[i] = 8'h00;
            ram[i] = 4'h0;
        end
    endtask

    task automatic go();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        pushbuttons = 4'h6;
        for (int i = 0; i < 65536; i++) rom8[i] = 12'h000;

        // Reset state
        begin_test();
        tick(2);
        check("rst_pc", pc, 12'h000);
        check("rst_accu", accu, 4'h0);
        check("rst_phase", phase, ST_FETCH);
        check("rst_flags", {c_flag, z_flag}, 2'b00);
        check("rst_halt", {halted, stack_err, ram_we}, 3'b000);
        check("rst_ff", ff_out, 4'h0);
        check("rst8_pc", pc8, 16'h0000);

        // LIT 5; ADDI 3; OUT; IN
        rom[0] = 8'h45; rom[1] = 8'hA3; rom[2] = 8'h51; rom[3] = 8'h50;
        go();
        tick(1);
        check("lit_phase", phase, ST_EXEC);
        check("lit_pc", pc, 12'h001);
        tick(5);
        check("add_accu", accu, 4'h8);
        check("out_ff", ff_out, 4'h8);
        check("add_flags", {c_flag, z_flag}, 2'b00);
        check("out_pc", pc, 12'h003);
        tick(2);
        check("in_accu", accu, 4'h6);
        check("in_ff_kept", ff_out, 4'h8);

        // LIT 9; ADDI 7; JC 0x020; JNZ 0x040 (not taken); JZ 0x050
        begin_test();
        rom[0] = 8'h49; rom[1] = 8'hA7; rom[2] = 8'h00; rom[3] = 8'h20;
        rom[12'h020] = 8'h90; rom[12'h021] = 8'h40;
        rom[12'h022] = 8'h80; rom[12'h023] = 8'h50;
        go();
        tick(4);
        check("wrap_accu", accu, 4'h0);
        check("wrap_flags", {c_flag, z_flag}, 2'b11);
        tick(1);
        check("jc_phase_fa", phase, ST_FETCH_ADDR);
        tick(1);
        check("jc_ram_addr", ram_addr, 12'h020);
        tick(1);
        check("jc_pc", pc, 12'h020);
        tick(3);
        check("jnz_fall", pc, 12'h022);
        tick(3);
        check("jz_pc", pc, 12'h050);

        // Same prefix with JNC: falls through
        begin_test();
        rom[0] = 8'h49; rom[1] = 8'hA7; rom[2] = 8'h10; rom[3] = 8'h20;
        go();
        tick(7);
        check("jnc_pc", pc, 12'h004);

        // LIT A; ST 0x123; LIT 0; LD; CMPM; CMPI 3; NANDI F; ADDM
        begin_test();
        rom[0] = 8'h4A; rom[1] = 8'h71; rom[2] = 8'h23; rom[3] = 8'h40;
        rom[4] = 8'h61; rom[5] = 8'h23; rom[6] = 8'h31; rom[7] = 8'h23;
        rom[8] = 8'h23; rom[9] = 8'hDF; rom[10] = 8'hB1; rom[11] = 8'h23;
        go();
        we0 = we_cnt;
        tick(3);
        check("st_we_pre", ram_we, 1'b0);
        check("idle_ram_addr", ram_addr, 12'h000);
        tick(1);
        check("st_we", ram_we, 1'b1);
        check("st_addr", ram_addr, 12'h123);
        check("st_wdata", ram_wdata, 4'hA);
        tick(1);
        check("st_we_post", ram_we, 1'b0);
        check("st_mem", ram[12'h123], 4'hA);
        tick(5);
        check("ld_accu", accu, 4'hA);
        check("ld_flags", {c_flag, z_flag}, 2'b00);
        tick(3);
        check("cmpm_flags", {c_flag, z_flag}, 2'b11);
        check("cmpm_accu", accu, 4'hA);
        tick(2);
        check("cmpi_flags", {c_flag, z_flag}, 2'b10);
        tick(2);
        check("nand_accu", accu, 4'h5);
        check("nand_flags", {c_flag, z_flag}, 2'b00);
        tick(3);
        check("addm_accu", accu, 4'hF);
        check("we_pulses", we_cnt - we0, 1);

        // JMP 0x010; CALL 0x100; CALL 0x200; RET; RET
        begin_test();
        rom[0] = 8'hC0; rom[1] = 8'h10;
        rom[12'h010] = 8'hE1; rom[12'h011] = 8'h00;
        rom[12'h100] = 8'hE2; rom[12'h101] = 8'h00;
        rom[12'h200] = 8'hF0; rom[12'h102] = 8'hF0;
        go();
        tick(6);
        check("call_pc", pc, 12'h100);
        tick(3);
        check("call2_pc", pc, 12'h200);
        tick(2);
        check("ret_inner", pc, 12'h102);
        tick(2);
        check("ret_outer", pc, 12'h012);
        check("ret_err", stack_err, 1'b0);

        // Five nested CALLs overflow a 4-deep stack
        begin_test();
        rom[0] = 8'hE0; rom[1] = 8'h04; rom[4] = 8'hE0; rom[5] = 8'h08;
        rom[8] = 8'hE0; rom[9] = 8'h0C; rom[12] = 8'hE0; rom[13] = 8'h10;
        rom[16] = 8'hE0; rom[17] = 8'h20;
        go();
        tick(12);
        check("nest4_pc", pc, 12'h010);
        check("nest4_ok", {halted, stack_err}, 2'b00);
        tick(3);
        check("ovf_state", {halted, stack_err}, 2'b11);
        check("ovf_phase", phase, ST_HALT);
        check("ovf_pc", pc, 12'h012);
        tick(4);
        check("halt_pc", pc, 12'h012);
        check("halt_paddr", prog_addr, 12'h012);

        // RET on an empty stack
        begin_test();
        rom[0] = 8'h43; rom[1] = 8'hF0; rom[2] = 8'h51;
        go();
        tick(4);
        check("unf_state", {halted, stack_err}, 2'b11);
        check("unf_pc", pc, 12'h002);
        tick(4);
        check("unf_frozen", {pc, accu, ff_out}, {12'h002, 4'h3, 4'h0});

        // Async reset mid-instruction (FETCH_ADDR of JMP, one return address stacked)
        begin_test();
        rom[0] = 8'h47; rom[1] = 8'hAB; rom[2] = 8'hE0; rom[3] = 8'h08;
        rom[8] = 8'hC0; rom[9] = 8'hF0;
        go();
        tick(7);
        check("pre_rst", {pc, accu, c_flag, z_flag}, {12'h008, 4'h2, 2'b10});
        tick(1);
        check("pre_rst_phase", phase, ST_FETCH_ADDR);
        #1 reset = 1'b1;
        #1;
        check("arst_state", {phase, pc, accu, c_flag, z_flag}, {ST_FETCH, 12'h000, 4'h0, 2'b00});
        rom[0] = 8'hF0;
        go();
        tick(1);
        check("arst_fetch0", {phase, pc}, {ST_EXEC, 12'h001});
        tick(1);
        check("arst_stack_empty", stack_err, 1'b1);

        // Async reset drops ram_we inside ST EXEC
        begin_test();
        rom[0] = 8'h71; rom[1] = 8'h23;
        go();
        tick(2);
        check("we_before_rst", ram_we, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("we_async_clr", ram_we, 1'b0);

        // Wide build: LIT 01; ADDI FF; JMP 0xABCD
        rom8[0] = 12'h401; rom8[1] = 12'hAFF; rom8[2] = 12'hC0A; rom8[3] = 12'hBCD;
        @(negedge clock);
        reset8 = 1'b0;
        tick(4);
        check("w8_accu", accu8, 8'h00);
        check("w8_flags", {c_flag8, z_flag8}, 2'b11);
        tick(3);
        check("w8_jmp", pc8, 16'hABCD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_cpu_p.md
# nibble_cpu_p

Parametrised successor of the nibble microprocessor: a multi-cycle accumulator CPU with configurable data width, address width and return-stack depth. It adds CALL/RET over a hardware return stack and a sticky halt on stack error. Program ROM and data RAM are external, and both are read combinationally. The core replaces the phase-toggle and 7-bit decoder scheme with an explicit fetch/execute FSM.

## Interface
- DATA_W, 4: accumulator, operand, RAM data and I/O width.
- PW, DATA_W+4: program word width, laid out as {opcode[3:0], oprnd[DATA_W-1:0]}.
- ADDR_W, 12: program and RAM address width. Constraint: ADDR_W ≤ DATA_W+PW.
- STACK_DEPTH, 4: number of return-stack entries, minimum 1.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- prog_addr  out  ADDR_W  ROM address.
- prog_data  in  PW  ROM word, valid in the same cycle.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data; always equals accu.
- ram_we  out  1  RAM write strobe.
- ram_rdata  in  DATA_W  RAM read data, combinational.
- pushbuttons  in  DATA_W  input port.
- ff_out  out  DATA_W  registered output port.
- accu  out  DATA_W  accumulator.
- pc  out  ADDR_W  program counter.
- c_flag, z_flag  out  1  carry and zero flags.
- phase  out  2  FSM state.
- halted  out  1  core stopped.
- stack_err  out  1  sticky stack overflow/underflow.

## Operation
- States:
  - FETCH: prog_addr=pc; latch instr and oprnd; pc+1.
  - FETCH_ADDR: entered only for 2-word opcodes; prog_addr=pc; latch addr_lo; pc+1.
  - EXEC
  - HALT: absorbing until reset.
- Transitions: FETCH→FETCH_ADDR for 2-word opcodes, otherwise FETCH→EXEC. FETCH_ADDR→EXEC. EXEC→FETCH, or EXEC→HALT on stack error.
- Effective address: ea = low ADDR_W bits of {oprnd, addr_lo}.
- Opcodes (2-word opcodes marked *):
  - 0 JC*
  - 1 JNC*
  - 2 CMPI
  - 3 CMPM*
  - 4 LIT: A=oprnd.
  - 5 IO: oprnd[0]=0 gives IN (A=pushbuttons); oprnd[0]=1 gives OUT (ff_out=A).
  - 6 LD*: A=RAM[ea].
  - 7 ST*: RAM[ea]=A.
  - 8 JZ*
  - 9 JNZ*
  - A ADDI
  - B ADDM*
  - C JMP*
  - D NANDI
  - E CALL*
  - F RET
- Arithmetic: ADD is computed at DATA_W+1 bits. C=carry out; Z=(result[DATA_W-1:0]==0).
- CMP: computes A+~B+1. C=1 iff A≥B (unsigned); Z=(A==B). A is unchanged.
- NAND: A=~(A&B); Z updated; C cleared.
- Flag updates: only CMP, ADD and NAND change flags. LIT, IN, LD, ST, OUT and jumps leave flags untouched.
- Conditional jumps: if taken, pc=ea at the end of EXEC; if not taken, pc keeps the post-fetch value.
- CALL: push pc (the address after the second word), then pc=ea.
- RET: pop into pc.
- CALL when the stack is full, or RET when it is empty: no push/pop, pc unchanged, stack_err=1, and the FSM goes to HALT.
- In HALT: no further writes to ram, accu, flags or ff_out; prog_addr=pc, frozen.
- pc wraps modulo 2^ADDR_W. Stack pointer never wraps.

## Timing
- Cycle counts: 1-word instructions take 2 cycles; 2-word instructions take 3.
- All architectural updates occur on the clock edge ending EXEC. Fetch latches occur on the edges ending FETCH/FETCH_ADDR.
- ram_addr=ea during EXEC; 0 otherwise.
- ram_we=1 only during EXEC of ST, for exactly one cycle.
- LD/CMPM/ADDM sample ram_rdata during EXEC.
- IN samples pushbuttons during EXEC, with no synchroniser. Synchronisation is the board's responsibility.
- OUT: ff_out changes on the EXEC edge.
- Reset, asynchronous at any point including mid-instruction:
  - pc, accu, flags, ff_out, instr, oprnd, addr_lo, stack pointer, stack_err and halted all go to 0.
  - phase goes to FETCH.
  - ram_we is deasserted immediately.
- The first fetch is from address 0 on the first edge after reset deasserts.

## Structure
- Shared package/include holds the opcode constants (OP_JC … OP_RET), the state encodings (ST_FETCH, ST_FETCH_ADDR, ST_EXEC, ST_HALT) and the predicate is_two_word(opcode).
- Sub-module call_stack:
  - Parameters: ADDR_W, STACK_DEPTH.
  - Ports: clock, reset, push, pop, din, dout, full, empty.
  - Synchronous push/pop; asynchronous clear of the pointer.
  - Simultaneous push and pop is illegal; the core never issues it.
- ALU is an inline combinational function of (opcode, A, B).

## Test plan
- Reset then LIT 5; ADDI 3; OUT (DATA_W=4) → accu=8, ff_out=8, C=0, Z=0; 6 cycles total.
- LIT 9; ADDI 7 → accu=0, C=1, Z=1. Follow with JC 0x020 → pc=0x020 after 3 cycles. JNC instead → falls through.
- ST 0x123 with A=0xA → ram_we high for exactly 1 cycle, ram_addr=0x123, ram_wdata=0xA. Then LIT 0; LD 0x123 → accu=0xA. CMPM 0x123 → Z=1, C=1.
- CALL 0x100 at 0x010, RET at 0x100 → pc=0x100, then 0x012. Nested CALLs to STACK_DEPTH=4 succeed; the 5th gives stack_err=1, halted=1, and pc is frozen. A separate RET with an empty stack gives the same result.
- Reset asserted during FETCH_ADDR of a JMP → next edge after release fetches address 0; accu=0, flags=0, stack empty.
- Build DATA_W=8, ADDR_W=16 → ADDI 0xFF on A=0x01 gives accu=0x00, C=1, Z=1; JMP 0xABCD reaches pc=0xABCD.
